sll_iter: RTL and testbench

- Multi-cycle logical left shifter: the left-shift counterpart of the team's combinational logical right shifter.
- Processes one shift-amount bit per clock, a logarithmic stage per cycle, so each stage needs only one N-bit 2:1 mux.
- Sits between the ALU operand registers and the writeback path, behind a valid/ready handshake on both sides.
- Used in area-constrained builds where a full single-cycle shifter is too large.

---
 rtl/sll_iter_pkg.sv | 19 +
 rtl/sll_stage.sv | 21 ++
 rtl/sll_iter.sv | 94 +++++++++
 tb/tb_sll_iter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/sll_iter_pkg.sv
// Shared types for the iterative left shifter.
// Holds the FSM state enum and stage-counter width helpers.
package sll_iter_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } sll_iter_state_t;

  localparam int SLL_N  = 32;
  localparam int SLL_L  = $clog2(SLL_N);
  localparam int SLL_KW = (SLL_L < 2) ? 1 : $clog2(SLL_L);

  function automatic int kw_of(int l);
    return (l < 2) ? 1 : $clog2(l);
  endfunction

endpackage

// File: rtl/sll_stage.sv
// One logarithmic stage: data_o = bit_i ? data_i << 2^k_i : data_i.
// Ports: data_i, bit_i (amount bit), k_i (stage index), data_o.
module sll_stage
  import sll_iter_pkg::*;
#(
  parameter int N  = SLL_N,
  parameter int KW = SLL_KW
) (
  input  logic [N-1:0]  data_i,
  input  logic          bit_i,
  input  logic [KW-1:0] k_i,
  output logic [N-1:0]  data_o
);

  always_comb begin
    data_o = data_i;
    if (bit_i)
      data_o = data_i << (1 << k_i);
  end

endmodule

// File: rtl/sll_iter.sv
// Multi-cycle logical left shifter, one shamt bit per clock.
// Ports: clk, rst (async low), in/out valid-ready, in, shamt, out, busy.
module sll_iter
  import sll_iter_pkg::*;
#(
  parameter  int N = 32,
  localparam int L = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in,
  input  logic [L-1:0] shamt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic         busy
);

  localparam int KW = kw_of(L);

  sll_iter_state_t state_q, state_d;
  logic [N-1:0]    data_q, data_d;
  logic [L-1:0]    amt_q, amt_d;
  logic [KW-1:0]   k_q, k_d;
  logic [N-1:0]    out_q, out_d;
  logic [N-1:0]    stage_o;

  sll_stage #(
    .N  (N),
    .KW (KW)
  ) u_stage (
    .data_i (data_q),
    .bit_i  (amt_q[k_q]),
    .k_i    (k_q),
    .data_o (stage_o)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      amt_q   <= '0;
      k_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      k_q     <= k_d;
      out_q   <= out_d;
    end
  end

  // out_q is separate from data_q so the result survives
  // the next operation's capture and shifting.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    amt_d   = amt_q;
    k_d     = k_q;
    out_d   = out_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d  = in;
          amt_d   = shamt;
          k_d     = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        data_d = stage_o;
        k_d    = k_q + 1'b1;
        if (k_q == KW'(L - 1)) begin
          out_d   = stage_o;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out       = out_q;

endmodule

// File: tb/tb_sll_iter.sv
// Self-checking bench for sll_iter (N=32).
// Scoreboard queue of expected shifts, compared on output handshake.
module tb_sll_iter;

  localparam int N = 32;
  localparam int L = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] din;
  logic [L-1:0] shamt;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] dout;
  logic         busy;

  int checks   = 0;
  int failures = 0;
  int popped   = 0;
  logic [N-1:0] exp_q[$];

  always #5 clk = ~clk;

  sll_iter #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (din),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dout),
    .busy      (busy)
  );

  task automatic chk(input string tag,
                     input logic [N-1:0] got,
                     input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: log handshakes seen before the edge, then advance.
  task automatic step();
    logic         fi;
    logic         fo;
    logic [N-1:0] ov;
    fi = in_valid && in_ready && rst;
    fo = out_valid && out_ready && rst;
    ov = dout;
    if (fi)
      exp_q.push_back(din << shamt);
    if (fo) begin
      chk("sb_nonempty", N'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        chk("sb_data", ov, exp_q.pop_front());
        popped++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [N-1:0] a,
                        input logic [L-1:0] s,
                        input int           stall,
                        input logic [N-1:0] want);
    int           lat;
    logic [N-1:0] held;
    din       = a;
    shamt     = s;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    chk("accept_rdy", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("shift_busy", busy, 1);
    chk("shift_nrdy", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("latency", lat, 5);
    chk("out", dout, want);
    held = dout;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      din      = ~a;
      shamt    = s + 1'b1;
      step();
      chk("stall_vld", out_valid, 1);
      chk("stall_hold", dout, held);
      chk("stall_nrdy", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("back_rdy", in_ready, 1);
    chk("vld_clr", out_valid, 0);
    chk("out_kept", dout, held);
  endtask

  initial begin
    int acc;
    int cyc;
    int pop0;

    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      din       = $urandom;
      shamt     = 5'($urandom_range(0, 31));
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      chk("rst_out", dout, 0);
      chk("rst_vld", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rdy", in_ready, 1);
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_rdy", in_ready, 1);
      chk("idle_busy", busy, 0);
    end

    run_op(32'h0000_00F1, 5'd4, 0, 32'h0000_0F10);
    run_op(32'hFFFF_FFFF, 5'd0, 0, 32'hFFFF_FFFF);
    run_op(32'h0000_0003, 5'd31, 0, 32'h8000_0000);
    run_op(32'h1234_5678, 5'd8, 6, 32'h3456_7800);

    din      = 32'hA5A5_A5A5;
    shamt    = 5'd13;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("mid_vld", out_valid, 0);
    chk("mid_rdy", in_ready, 1);
    chk("mid_busy", busy, 0);
    chk("mid_out", dout, 0);
    exp_q.delete();
    step();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("mid_novld", out_valid, 0);
    end
    run_op(32'h0000_0001, 5'd1, 0, 32'h0000_0002);

    acc  = 0;
    cyc  = 0;
    pop0 = popped;
    while (acc < 1000 && cyc < 40000) begin
      din       = $urandom;
      shamt     = 5'($urandom_range(0, 31));
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = 1'b1;
      if (in_ready)
        acc++;
      step();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc       = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      step();
      cyc++;
    end
    chk("rand_cnt", popped - pop0, 1000);
    chk("drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
